// File: rtl/protocol_ctrl.sv
// Purpose : host-side transaction controller; sequences token, data and handshake
//           packets, waits for device responses and retries on NAK/error/timeout.
// Latency : start sampled in IDLE -> pktready_bs pulses one cycle after TOKEN entry
//           (second rising edge); done pulses one cycle in FINISH.
// Backpressure: each packet is held on pid/addr/endp/data/pkttype until tx_done;
//           tx_done is only honoured after the packet's pktready_bs strobe.
// Ports   : clk/rst (sync, active-high); start/is_in/req_* request;
//           pid/addr/endp/data/pkttype/pktready_bs/tx_done output pipe;
//           writing bus direction; rx_* input pipe; done/success/rd_data result.
module protocol_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_in,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_endp,
  input  logic [63:0] req_data,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [63:0] data,
  output logic        pkttype,
  output logic        pktready_bs,
  input  logic        tx_done,
  output logic        writing,
  input  logic        rx_pktready,
  input  logic        rx_error,
  input  logic        rx_ack,
  input  logic        rx_nak,
  input  logic [63:0] rx_data,
  output logic        done,
  output logic        success,
  output logic [63:0] rd_data
);

  localparam int AW = $clog2(MAX_RETRY) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    IDLE, TOKEN, DATA_OUT, WAIT_HS, WAIT_DATA, SEND_HS, FINISH
  } state_e;

  state_e         state_q, state_d;
  logic           is_in_q, is_in_d;
  logic [6:0]     raddr_q, raddr_d;
  logic [3:0]     rendp_q, rendp_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [AW-1:0]  attempt_q, attempt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           sent_q, sent_d;     // strobe already issued in current send state
  logic           hs_ack_q, hs_ack_d; // 1 = handshake to send is ACK, 0 = NAK
  logic           success_q, success_d;
  logic [63:0]    rd_data_q, rd_data_d;
  logic [3:0]     pid_q, pid_d;
  logic [6:0]     addr_q, addr_d;
  logic [3:0]     endp_q, endp_d;
  logic [63:0]    data_q, data_d;
  logic           pkttype_q, pkttype_d;
  logic           pkt_rdy_q, pkt_rdy_d;
  logic           retry;
  logic           timeout;

  assign timeout = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    is_in_d   = is_in_q;
    raddr_d   = raddr_q;
    rendp_d   = rendp_q;
    rdata_d   = rdata_q;
    attempt_d = attempt_q;
    sent_d    = sent_q;
    hs_ack_d  = hs_ack_q;
    success_d = success_q;
    rd_data_d = rd_data_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    pkttype_d = pkttype_q;
    pkt_rdy_d = 1'b0;
    retry     = 1'b0;
    tmo_d     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_in_d   = is_in;
          raddr_d   = req_addr;
          rendp_d   = req_endp;
          rdata_d   = req_data;
          attempt_d = AW'(1);
          state_d   = TOKEN;
        end
      end
      TOKEN: begin
        if (!sent_q) begin
          sent_d    = 1'b1;
          pkt_rdy_d = 1'b1;
          pid_d     = is_in_q ? PID_IN : PID_OUT;
          addr_d    = raddr_q;
          endp_d    = rendp_q;
          pkttype_d = 1'b0;
        end else if (tx_done) begin
          state_d = is_in_q ? WAIT_DATA : DATA_OUT;
        end
      end
      DATA_OUT: begin
        if (!sent_q) begin
          sent_d    = 1'b1;
          pkt_rdy_d = 1'b1;
          pid_d     = PID_DATA0;
          data_d    = rdata_q;
          pkttype_d = 1'b1;
        end else if (tx_done) begin
          state_d = WAIT_HS;
        end
      end
      WAIT_HS: begin
        // A data packet here is a protocol error; any response beats timeout.
        if (rx_error || rx_nak || rx_pktready) begin
          retry = 1'b1;
        end else if (rx_ack) begin
          success_d = 1'b1;
          state_d   = FINISH;
        end else if (timeout) begin
          retry = 1'b1;
        end
      end
      WAIT_DATA: begin
        // A handshake here is a protocol error and is NAKed like a bad packet.
        if (rx_error || rx_ack || rx_nak) begin
          hs_ack_d = 1'b0;
          state_d  = SEND_HS;
        end else if (rx_pktready) begin
          rd_data_d = rx_data;
          hs_ack_d  = 1'b1;
          state_d   = SEND_HS;
        end else if (timeout) begin
          retry = 1'b1;
        end
      end
      SEND_HS: begin
        if (!sent_q) begin
          sent_d    = 1'b1;
          pkt_rdy_d = 1'b1;
          pid_d     = hs_ack_q ? PID_ACK : PID_NAK;
          pkttype_d = 1'b0;
        end else if (tx_done) begin
          if (hs_ack_q) begin
            success_d = 1'b1;
            state_d   = FINISH;
          end else begin
            retry = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (retry) begin
      if (attempt_q < AW'(MAX_RETRY)) begin
        attempt_d = attempt_q + AW'(1);
        state_d   = TOKEN;
      end else begin
        success_d = 1'b0;
        state_d   = FINISH;
      end
    end

    // Every state change re-arms the send strobe for the next send state.
    if (state_d != state_q) begin
      sent_d = 1'b0;
    end

    // Timer runs only while staying in a wait state; any entry starts from zero.
    if ((state_q == WAIT_HS || state_q == WAIT_DATA) && state_d == state_q) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_in_q   <= 1'b0;
      raddr_q   <= '0;
      rendp_q   <= '0;
      rdata_q   <= '0;
      attempt_q <= '0;
      tmo_q     <= '0;
      sent_q    <= 1'b0;
      hs_ack_q  <= 1'b0;
      success_q <= 1'b0;
      rd_data_q <= '0;
      pid_q     <= '0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      pkttype_q <= 1'b0;
      pkt_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_in_q   <= is_in_d;
      raddr_q   <= raddr_d;
      rendp_q   <= rendp_d;
      rdata_q   <= rdata_d;
      attempt_q <= attempt_d;
      tmo_q     <= tmo_d;
      sent_q    <= sent_d;
      hs_ack_q  <= hs_ack_d;
      success_q <= success_d;
      rd_data_q <= rd_data_d;
      pid_q     <= pid_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      data_q    <= data_d;
      pkttype_q <= pkttype_d;
      pkt_rdy_q <= pkt_rdy_d;
    end
  end

  assign pid         = pid_q;
  assign addr        = addr_q;
  assign endp        = endp_q;
  assign data        = data_q;
  assign pkttype     = pkttype_q;
  assign pktready_bs = pkt_rdy_q;
  assign writing     = (state_q == TOKEN) || (state_q == DATA_OUT) || (state_q == SEND_HS);
  assign done        = (state_q == FINISH);
  assign success     = success_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_protocol_ctrl.sv
module tb_protocol_ctrl;
  localparam int TMO = 16;
  localparam int MR  = 8;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_DATA0 = 4'b0011,
                         P_ACK = 4'b0010, P_NAK = 4'b1010;

  logic        clk = 1'b0;
  logic        rst, start, is_in, tx_done, rx_pktready, rx_error, rx_ack, rx_nak;
  logic [6:0]  req_addr, addr;
  logic [3:0]  req_endp, endp, pid;
  logic [63:0] req_data, data, rx_data, rd_data;
  logic        pkttype, pktready_bs, writing, done, success;

  int          checks = 0;
  int          errors = 0;
  int          plan [8];      // per-attempt response: 0 ok, 1 nak/bad, 2 err, 3 proto err, 4 silent
  logic [63:0] rxd_v;
  logic [63:0] last_rd;
  bit          force_late;

  protocol_ctrl #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .is_in(is_in), .req_addr(req_addr),
    .req_endp(req_endp), .req_data(req_data), .pid(pid), .addr(addr), .endp(endp),
    .data(data), .pkttype(pkttype), .pktready_bs(pktready_bs), .tx_done(tx_done),
    .writing(writing), .rx_pktready(rx_pktready), .rx_error(rx_error), .rx_ack(rx_ack),
    .rx_nak(rx_nak), .rx_data(rx_data), .done(done), .success(success), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic clear_rx();
    rx_pktready = 1'b0; rx_error = 1'b0; rx_ack = 1'b0; rx_nak = 1'b0;
  endtask

  // Runs one transaction as the output/input pipes would, following plan[] per attempt.
  task automatic run_txn(input bit in_t, input logic [6:0] a, input logic [3:0] e,
                         input logic [63:0] d, input string nm);
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [3:0] cur;
    bit exp_s, fin, first, bad;
    int att, budget, code, c, k, wcnt, n_tok;
    // reference: expected packet sequence and outcome from the attempt plan
    exp_s = 1'b0;
    for (int i = 0; i < MR; i++) begin
      exp_q.push_back(in_t ? P_IN : P_OUT);
      if (!in_t) exp_q.push_back(P_DATA0);
      if (in_t && plan[i] != 4) exp_q.push_back(plan[i] == 0 ? P_ACK : P_NAK);
      if (plan[i] == 0) begin exp_s = 1'b1; break; end
    end
    @(negedge clk);
    is_in = in_t; req_addr = a; req_endp = e; req_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; is_in = ~in_t; req_addr = 7'($urandom); req_endp = 4'($urandom);
    req_data = {$urandom, $urandom};
    att = 0; fin = 1'b0; first = 1'b1;
    while (!fin) begin
      budget = 0;
      while (!pktready_bs && !done && budget < 100) begin @(negedge clk); budget++; end
      if (budget >= 100) begin
        checks++; errors++;
        $display("FAIL %s: no packet or done within 100 cycles", nm);
        return;
      end
      if (first) begin
        checks++;
        if (budget !== 1) begin errors++; $display("FAIL %s latency: got %0d extra cycles, want 1", nm, budget); end
        first = 1'b0;
      end
      if (done) begin
        fin = 1'b1;
      end else begin
        cur = pid;
        got_q.push_back(cur);
        checks++;
        if (writing !== 1'b1) begin errors++; $display("FAIL %s writing_send: got %b want 1", nm, writing); end
        if (cur == P_OUT || cur == P_IN) begin
          checks++;
          if ({addr, endp, pkttype} !== {a, e, 1'b0}) begin
            errors++; $display("FAIL %s token_fields: got %h/%h/%b want %h/%h/0", nm, addr, endp, pkttype, a, e);
          end
        end
        if (cur == P_DATA0) begin
          checks++;
          if ({data, pkttype} !== {d, 1'b1}) begin
            errors++; $display("FAIL %s data_fields: got %h/%b want %h/1", nm, data, pkttype, d);
          end
        end
        @(negedge clk);
        checks++;
        if (pktready_bs !== 1'b0) begin errors++; $display("FAIL %s strobe_width: got %b want 0", nm, pktready_bs); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checks++;
        if (pid !== cur) begin errors++; $display("FAIL %s pid_hold: got %h want %h", nm, pid, cur); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (cur == P_DATA0 || cur == P_IN) begin
          code = (att < MR) ? plan[att] : 4;
          att++;
          c = force_late ? TMO : int'($urandom_range(1, TMO));
          wcnt = 0; k = 1;
          while (!writing && !done && k <= 3 * TMO) begin
            wcnt++;
            start = (k == 1);   // must be ignored outside IDLE
            clear_rx();
            rx_data = {$urandom, $urandom};
            if (code != 4 && k == c) begin
              if (!in_t) begin
                case (code)
                  0: rx_ack = 1'b1;
                  1: rx_nak = 1'b1;
                  2: rx_error = 1'b1;
                  default: rx_pktready = 1'b1;
                endcase
              end else begin
                case (code)
                  0: begin rx_pktready = 1'b1; rx_data = rxd_v; end
                  1: begin rx_pktready = 1'b1; rx_error = 1'b1; end
                  2: rx_ack = 1'b1;
                  default: rx_nak = 1'b1;
                endcase
              end
            end
            @(negedge clk);
            k++;
          end
          start = 1'b0;
          clear_rx();
          checks++;
          if (wcnt !== ((code == 4) ? TMO : c)) begin
            errors++; $display("FAIL %s wait_len: got %0d cycles, want %0d", nm, wcnt, (code == 4) ? TMO : c);
          end
        end
      end
    end
    checks++;
    if (success !== exp_s) begin errors++; $display("FAIL %s success: got %b want %b", nm, success, exp_s); end
    bad = (got_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL %s pid_seq: got %0d packets, want %0d (or pid order differs)", nm, got_q.size(), exp_q.size());
    end
    if (!in_t) begin
      n_tok = 0;
      foreach (got_q[i]) if (got_q[i] == P_OUT) n_tok++;
      checks++;
      if (n_tok !== (exp_q.size() / 2)) begin
        errors++; $display("FAIL %s out_tokens: got %0d want %0d", nm, n_tok, exp_q.size() / 2);
      end
    end
    if (in_t && exp_s) last_rd = rxd_v;
    checks++;
    if (rd_data !== last_rd) begin errors++; $display("FAIL %s rd_data: got %h want %h", nm, rd_data, last_rd); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || success !== exp_s) begin
      errors++; $display("FAIL %s done_pulse: got done=%b success=%b want 0/%b", nm, done, success, exp_s);
    end
  endtask

  task automatic set_plan(input int p0, input int p1, input int rest);
    for (int i = 0; i < MR; i++) plan[i] = rest;
    plan[0] = p0; plan[1] = p1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({pktready_bs, writing, done, success, pid, addr, endp, pkttype, data, rd_data} !== '0) begin
      errors++; $display("FAIL reset_values: got pid=%h addr=%h wr=%b rdy=%b want all zero", pid, addr, writing, pktready_bs);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pktready_bs !== 1'b0 || writing !== 1'b0) begin
        errors++; $display("FAIL reset_start_ignored: got rdy=%b wr=%b want 0/0", pktready_bs, writing);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_out_basic();
    set_plan(0, 0, 0);
    run_txn(1'b0, 7'd5, 4'd4, 64'hDEAD_BEEF_0123_4567, "out_basic");
  endtask

  task automatic test_in_basic();
    set_plan(0, 0, 0);
    rxd_v = 64'hCAFE_F00D_0000_0001;
    run_txn(1'b1, 7'd9, 4'd2, 64'h0, "in_basic");
  endtask

  task automatic test_out_nak();
    set_plan(1, 1, 1);
    run_txn(1'b0, 7'd17, 4'd1, 64'h1111_2222_3333_4444, "out_nak");
  endtask

  task automatic test_in_timeout();
    set_plan(4, 4, 4);
    run_txn(1'b1, 7'd3, 4'd7, 64'h0, "in_timeout");
  endtask

  task automatic test_in_error_retry();
    set_plan(1, 0, 0);
    rxd_v = 64'h0123_4567_89AB_CDEF;
    run_txn(1'b1, 7'd100, 4'd15, 64'h0, "in_err_retry");
  endtask

  task automatic test_late_response();
    force_late = 1'b1;
    set_plan(3, 0, 0);
    run_txn(1'b0, 7'd44, 4'd3, 64'h5555_AAAA_5555_AAAA, "late_out");
    set_plan(2, 0, 0);
    rxd_v = 64'hFEED_FACE_1234_0000;
    run_txn(1'b1, 7'd45, 4'd6, 64'h0, "late_in");
    force_late = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b;
    @(negedge clk);
    is_in = 1'b0; req_addr = 7'd21; req_endp = 4'd8; req_data = 64'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      b = 0;
      while (!pktready_bs && b < 20) begin @(negedge clk); b++; end
      if (p == 0) begin
        @(negedge clk); tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
      end
    end
    checks++;
    if (pid !== P_DATA0) begin errors++; $display("FAIL rst_mid_setup: got pid %h want %h", pid, P_DATA0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    checks++;
    if ({pktready_bs, writing, done, success, pid, addr, endp, pkttype, data, rd_data} !== '0) begin
      errors++; $display("FAIL rst_mid_values: got pid=%h data=%h rd=%h wr=%b want all zero", pid, data, rd_data, writing);
    end
    set_plan(0, 0, 0);
    run_txn(1'b0, 7'd22, 4'd9, 64'hABCD_0000_1234_5678, "after_rst");
  endtask

  task automatic test_random();
    bit        t;
    logic [6:0] a;
    logic [3:0] e;
    logic [63:0] d;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < MR; i++) plan[i] = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 4));
      t = 1'($urandom); a = 7'($urandom); e = 4'($urandom); d = {$urandom, $urandom};
      rxd_v = {$urandom, $urandom};
      run_txn(t, a, e, d, "random");
    end
  endtask

  task automatic test_back_to_back();
    set_plan(0, 0, 0);
    rxd_v = 64'h0000_0000_FFFF_0001;
    run_txn(1'b1, 7'd1, 4'd1, 64'h0, "b2b_in");
    run_txn(1'b0, 7'd2, 4'd2, 64'h2, "b2b_out");
    run_txn(1'b1, 7'd3, 4'd3, 64'h0, "b2b_in2");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_in = 1'b0; tx_done = 1'b0;
    req_addr = '0; req_endp = '0; req_data = '0; rx_data = '0;
    clear_rx();
    rxd_v = '0; last_rd = '0; force_late = 1'b0;
    test_reset();
    test_out_basic();
    test_in_basic();
    test_out_nak();
    test_in_timeout();
    test_in_error_retry();
    test_late_response();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
